// File: rtl/aes_composite_enc_cbc.sv
// AES-128 encryption datapath that applies UNROLL rounds per clock, with ECB/CBC
// chaining through an IV register and optional bit-inverted register storage.
module aes_composite_enc_cbc #(
    parameter int UNROLL  = 1,
    parameter bit INV_REG = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [127:0] Kin,
    input  logic         Krdy,
    output logic         Kvld,
    input  logic [127:0] IVin,
    input  logic         IVrdy,
    input  logic         MODE,
    input  logic [127:0] Din,
    input  logic         Drdy,
    output logic [127:0] Dout,
    output logic         Dvld,
    output logic         BSY
);

    localparam int NR = 10 / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_composite_enc_cbc: UNROLL must be 1, 2, 5 or 10");
    end

    localparam logic [NR:0] CNT_IDLE  = {{NR{1'b0}}, 1'b1};
    localparam logic [NR:0] CNT_FIRST = CNT_IDLE << 1;

    typedef enum logic [0:0] {
        PH_IDLE = 1'b0,
        PH_RUN  = 1'b1
    } phase_t;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic and the AES round primitives
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] y;
        logic [7:0] inv;
        y = a;
        for (int i = 0; i < 6; i++) begin
            y = gf_mul(gf_mul(y, y), a);
        end
        inv = gf_mul(y, y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] sb;
        logic [127:0] sr;
        logic [127:0] mc;
        logic [7:0]   a0, a1, a2, a3;
        sb = 128'h0;
        sr = 128'h0;
        mc = 128'h0;
        for (int b = 0; b < 16; b++) begin
            sb[8*b +: 8] = sbox(st[8*b +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[8*(15-(4*c+r)) +: 8] = sb[8*(15-(4*((c+r)%4)+r)) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[8*(15-4*c) +: 8];
            a1 = sr[8*(14-4*c) +: 8];
            a2 = sr[8*(13-4*c) +: 8];
            a3 = sr[8*(12-4*c) +: 8];
            mc[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return (last ? sr : mc) ^ rk;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Physical <-> logical view of the wide registers; the map is its own inverse.
    function automatic logic [127:0] reg_map(input logic [127:0] v);
        return INV_REG ? ~v : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    phase_t       phase_r;
    phase_t       phase_nxt_s;
    logic [127:0] key_r;
    logic [127:0] chain_r;
    logic [127:0] state_r;
    logic [127:0] rkey_r;
    logic [7:0]   rcon_r;
    logic [NR:0]  cnt_r;
    logic         mode_r;
    logic [127:0] dout_r;
    logic         dvld_r;
    logic         kvld_r;

    logic         bsy_s;
    logic         done_s;
    logic         acc_key_s;
    logic         acc_iv_s;
    logic         acc_dat_s;
    logic [127:0] keff_s;
    logic [127:0] init_s;
    logic [127:0] rnd_st_s [UNROLL+1];
    logic [127:0] rnd_rk_s [UNROLL+1];
    logic [7:0]   rnd_rc_s [UNROLL+1];

    assign bsy_s  = (phase_r == PH_RUN);
    assign done_s = bsy_s & cnt_r[NR];

    // Accept decisions and whitening of an incoming block; a same-edge key load is used directly.
    always_comb begin
        acc_key_s = Krdy & ~bsy_s;
        acc_iv_s  = IVrdy & ~bsy_s;
        acc_dat_s = Drdy & ~bsy_s;
        keff_s    = acc_key_s ? Kin : reg_map(key_r);
        init_s    = Din ^ (MODE ? reg_map(chain_r) : 128'h0) ^ keff_s;
    end

    // Unrolled round chain: each stage expands the key and applies one round.
    always_comb begin
        rnd_st_s[0] = reg_map(state_r);
        rnd_rk_s[0] = reg_map(rkey_r);
        rnd_rc_s[0] = rcon_r;
        for (int j = 0; j < UNROLL; j++) begin
            rnd_rk_s[j+1] = key_expand(rnd_rk_s[j], rnd_rc_s[j]);
            rnd_rc_s[j+1] = xtime(rnd_rc_s[j]);
            rnd_st_s[j+1] = aes_round(rnd_st_s[j], rnd_rk_s[j+1], cnt_r[NR] && (j == UNROLL - 1));
        end
    end

    // Phase register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_r <= PH_IDLE;
        end else if (EN) begin
            phase_r <= phase_nxt_s;
        end
    end

    // Next phase: idle until a block is accepted, run until the last round cycle.
    always_comb begin
        phase_nxt_s = phase_r;
        case (phase_r)
            PH_IDLE: begin
                if (Drdy) phase_nxt_s = PH_RUN;
                else      phase_nxt_s = PH_IDLE;
            end
            PH_RUN: begin
                if (cnt_r[NR]) phase_nxt_s = PH_IDLE;
                else           phase_nxt_s = PH_RUN;
            end
            default: phase_nxt_s = PH_IDLE;
        endcase
    end

    // Key, chain and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_r   <= reg_map(128'h0);
            chain_r <= reg_map(128'h0);
            dout_r  <= 128'h0;
            dvld_r  <= 1'b0;
            kvld_r  <= 1'b0;
        end else if (EN) begin
            kvld_r <= acc_key_s;
            dvld_r <= done_s;
            if (acc_key_s) key_r <= reg_map(Kin);
            if (done_s) dout_r <= rnd_st_s[UNROLL];
            // A CBC completion owns the chain register on its edge.
            if (done_s && mode_r)  chain_r <= reg_map(rnd_st_s[UNROLL]);
            else if (acc_iv_s)     chain_r <= reg_map(IVin);
        end
    end

    // Round state, round key, rcon and one-hot progress counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= reg_map(128'h0);
            rkey_r  <= reg_map(128'h0);
            rcon_r  <= 8'h01;
            cnt_r   <= CNT_IDLE;
            mode_r  <= 1'b0;
        end else if (EN) begin
            if (acc_dat_s) begin
                state_r <= reg_map(init_s);
                rkey_r  <= reg_map(keff_s);
                rcon_r  <= 8'h01;
                cnt_r   <= CNT_FIRST;
                mode_r  <= MODE;
            end else if (bsy_s) begin
                state_r <= reg_map(rnd_st_s[UNROLL]);
                rkey_r  <= reg_map(rnd_rk_s[UNROLL]);
                if (done_s) begin
                    cnt_r  <= CNT_IDLE;
                    rcon_r <= 8'h01;
                end else begin
                    cnt_r  <= cnt_r << 1;
                    rcon_r <= rnd_rc_s[UNROLL];
                end
            end
        end
    end

    assign Dout = dout_r;
    assign Dvld = dvld_r;
    assign Kvld = kvld_r;
    assign BSY  = bsy_s;

endmodule

// File: tb/tb_aes_composite_enc_cbc.sv
// Directed bench: known-answer vectors on every UNROLL/INV_REG variant, plus hand
// sequences for CBC back-to-back, busy rejection, clock-enable stall and mid-block reset.
module tb_aes_composite_enc_cbc;

    localparam int NDUT = 5;
    localparam int EXP_LAT [NDUT] = '{10, 10, 5, 2, 1};

    localparam logic [127:0] K_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_STD = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1    = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2    = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] E1    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    typedef struct {
        logic [127:0] key;
        logic [127:0] iv;
        logic         mode;
        logic         simul;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RST, EN, Krdy, IVrdy, MODE, Drdy;
    logic [127:0] Kin, IVin, Din;
    logic [127:0] dout_w [NDUT];
    logic         dvld_w [NDUT];
    logic         kvld_w [NDUT];
    logic         bsy_w  [NDUT];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes_composite_enc_cbc #(
            .UNROLL ((g < 2) ? 1 : (g == 2) ? 2 : (g == 3) ? 5 : 10),
            .INV_REG(g != 1)
        ) u_dut (
            .CLK  (CLK),
            .RST  (RST),
            .EN   (EN),
            .Kin  (Kin),
            .Krdy (Krdy),
            .Kvld (kvld_w[g]),
            .IVin (IVin),
            .IVrdy(IVrdy),
            .MODE (MODE),
            .Din  (Din),
            .Drdy (Drdy),
            .Dout (dout_w[g]),
            .Dvld (dvld_w[g]),
            .BSY  (bsy_w[g])
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Krdy  = 1'b0;
        IVrdy = 1'b0;
        Drdy  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        EN  = 1'b1;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Waits for Dvld on the UNROLL=1 instance; n stays 0 if the budget expires.
    task automatic wait_dvld(input int budget, output int n);
        n = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (dvld_w[0] === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic chk_pair(input string name, input logic [127:0] exp);
        chk({name, "_dout0"}, dout_w[0], exp);
        chk({name, "_dout1"}, dout_w[1], exp);
        chk({name, "_dvld1"}, {127'h0, dvld_w[1]}, 128'h1);
        chk({name, "_bsy0"}, {127'h0, bsy_w[0]}, 128'h0);
    endtask

    initial begin
        vec_t         vecs [5];
        int           lat  [NDUT];
        int           hits [NDUT];
        logic [127:0] got  [NDUT];
        logic         bsyd [NDUT];
        int           n;

        vecs[0] = '{key: K_SEQ, iv: 128'h0, mode: 1'b0, simul: 1'b0,
                    pt: 128'h00112233445566778899aabbccddeeff,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{key: K_STD, iv: 128'h0, mode: 1'b0, simul: 1'b1,
                    pt: 128'h3243f6a8885a308d313198a2e0370734,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{key: K_STD, iv: K_SEQ, mode: 1'b1, simul: 1'b0, pt: P1, ct: C1};
        vecs[3] = '{key: K_STD, iv: 128'h0, mode: 1'b0, simul: 1'b1, pt: P1, ct: E1};
        vecs[4] = '{key: 128'h0, iv: 128'h0, mode: 1'b0, simul: 1'b0, pt: 128'h0,
                    ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        Kin = 128'h0; IVin = 128'h0; Din = 128'h0; MODE = 1'b0;
        do_reset();

        // Known-answer vectors on every variant.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("v%0d_rst_dout%0d", v, i), dout_w[i], 128'h0);
                chk($sformatf("v%0d_rst_flags%0d", v, i),
                    {125'h0, dvld_w[i], kvld_w[i], bsy_w[i]}, 128'h0);
            end
            IVin = vecs[v].iv; IVrdy = 1'b1;
            if (!vecs[v].simul) begin
                Kin = vecs[v].key; Krdy = 1'b1;
            end
            tick();
            idle_inputs();
            if (!vecs[v].simul) begin
                for (int i = 0; i < NDUT; i++)
                    chk($sformatf("v%0d_kvld%0d", v, i), {127'h0, kvld_w[i]}, 128'h1);
            end
            Din = vecs[v].pt; MODE = vecs[v].mode; Drdy = 1'b1;
            if (vecs[v].simul) begin
                Kin = vecs[v].key; Krdy = 1'b1;
            end
            tick();
            idle_inputs();
            if (vecs[v].simul) begin
                for (int i = 0; i < NDUT; i++)
                    chk($sformatf("v%0d_kvld%0d", v, i), {127'h0, kvld_w[i]}, 128'h1);
            end
            for (int i = 0; i < NDUT; i++) begin
                lat[i] = 0; hits[i] = 0; got[i] = 128'h0; bsyd[i] = 1'b1;
            end
            for (int k = 1; k <= 12; k++) begin
                tick();
                for (int i = 0; i < NDUT; i++) begin
                    if (dvld_w[i] === 1'b1) begin
                        hits[i]++;
                        if (lat[i] == 0) begin
                            lat[i] = k; got[i] = dout_w[i]; bsyd[i] = bsy_w[i];
                        end
                    end
                end
            end
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("v%0d_lat%0d", v, i), lat[i], EXP_LAT[i]);
                chk($sformatf("v%0d_dout%0d", v, i), got[i], vecs[v].ct);
                chk($sformatf("v%0d_bsy_at_dvld%0d", v, i), {127'h0, bsyd[i]}, 128'h0);
                chk($sformatf("v%0d_dvld_pulses%0d", v, i), hits[i], 1);
            end
        end

        // CBC: Krdy+IVrdy+Drdy together use Kin and the old chain; P2 issued on the Dvld cycle.
        do_reset();
        Kin = K_SEQ; Krdy = 1'b1; IVin = K_SEQ; IVrdy = 1'b1;
        tick();
        Kin = K_STD; Krdy = 1'b1; IVin = {128{1'b1}}; IVrdy = 1'b1;
        Din = P1; MODE = 1'b1; Drdy = 1'b1;
        tick();
        idle_inputs();
        wait_dvld(20, n);
        chk("cbc1_lat", n, 10);
        chk_pair("cbc1", C1);
        Din = P2; MODE = 1'b1; Drdy = 1'b1;
        tick();
        idle_inputs();
        wait_dvld(20, n);
        chk("cbc2_lat", n, 10);
        chk_pair("cbc2", C2);

        // Busy rejection: mid-block requests leave key, chain and result untouched.
        do_reset();
        Kin = K_STD; Krdy = 1'b1; IVin = K_SEQ; IVrdy = 1'b1;
        tick();
        idle_inputs();
        Din = P1; MODE = 1'b0; Drdy = 1'b1;
        tick();
        idle_inputs();
        tick(); tick(); tick();
        Kin = K_SEQ; Krdy = 1'b1; IVin = {128{1'b1}}; IVrdy = 1'b1;
        Din = 128'h0; MODE = 1'b1; Drdy = 1'b1;
        tick();
        idle_inputs();
        chk("busy_kvld", {126'h0, kvld_w[0], kvld_w[1]}, 128'h0);
        wait_dvld(20, n);
        chk("busy_lat", n, 6);
        chk_pair("busy_res", E1);
        Din = P1; MODE = 1'b1; Drdy = 1'b1;
        tick();
        idle_inputs();
        wait_dvld(20, n);
        chk("busy_follow_lat", n, 10);
        chk_pair("busy_follow", C1);

        // Clock-enable stall of three cycles before round 4.
        do_reset();
        Kin = K_STD; Krdy = 1'b1; Din = vecs[1].pt; MODE = 1'b0; Drdy = 1'b1;
        tick();
        idle_inputs();
        tick(); tick(); tick();
        EN = 1'b0;
        Din = P2; Drdy = 1'b1; Krdy = 1'b1;
        tick(); tick(); tick();
        idle_inputs();
        chk("en_hold_bsy", {127'h0, bsy_w[0]}, 128'h1);
        chk("en_hold_dvld", {127'h0, dvld_w[0]}, 128'h0);
        EN = 1'b1;
        wait_dvld(20, n);
        chk("en_lat", n, 7);
        chk_pair("en_res", vecs[1].ct);

        // Reset at round 5 aborts the block; key returns to zero.
        do_reset();
        Kin = K_STD; Krdy = 1'b1; Din = vecs[1].pt; MODE = 1'b0; Drdy = 1'b1;
        tick();
        idle_inputs();
        tick(); tick(); tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_mid_dout", dout_w[0], 128'h0);
        chk("rst_mid_flags", {126'h0, dvld_w[0], bsy_w[0]}, 128'h0);
        wait_dvld(12, n);
        chk("rst_mid_no_dvld", n, 0);
        Din = 128'h0; MODE = 1'b0; Drdy = 1'b1;
        tick();
        idle_inputs();
        wait_dvld(20, n);
        chk("rst_next_lat", n, 10);
        chk_pair("rst_next", vecs[4].ct);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
